// File: rtl/trace_drain.sv
// Trace readout drain: frames a requested number of 64-bit trace entries as
// header + data words + XOR checksum trailer on a 32-bit enq-style stream.
//
// state | meaning
// IDLE  | waiting for start; out value held at 0
// HDR   | presenting header {tag, count}
// DATA  | pass-through of trace words, checksum and alignment tracking
// TRAIL | presenting XOR checksum trailer

module trace_drain #(
   parameter int          owidth = 32,
   parameter int          depth  = 1024,
   parameter logic [7:0]  tag    = 8'hA5
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     start__ENA,
   input  logic [$clog2(depth):0]   start_count,
   output logic                     start__RDY,
   input  logic                     abort__ENA,
   output logic                     abort__RDY,
   input  logic [owidth-1:0]        in_first,
   input  logic                     in_first__RDY,
   input  logic                     in_last,
   output logic                     in_deq__ENA,
   input  logic                     in_deq__RDY,
   output logic                     out_enq__ENA,
   output logic [owidth-1:0]        out_enq_v,
   input  logic                     out_enq__RDY,
   output logic                     busy,
   output logic                     error
);

   localparam int CW = $clog2(depth) + 1;
   localparam int RW = CW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);

   typedef enum logic [1:0] {IDLE, HDR, DATA, TRAIL} state_t;

   state_t             state_q, state_d;
   logic [RW-1:0]      remain_q, remain_d;
   logic [owidth-1:0]  csum_q, csum_d;
   logic               odd_q, odd_d;
   logic               err_q, err_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [23:0]        hdr_count;
   logic               xfer;

   assign hdr_count  = 24'(cnt_q);
   assign start__RDY = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign abort__RDY = 1'b1;
   assign error      = err_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         remain_q <= '0;
         csum_q   <= '0;
         odd_q    <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         csum_q   <= csum_d;
         odd_q    <= odd_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      remain_d     = remain_q;
      csum_d       = csum_q;
      odd_d        = odd_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      in_deq__ENA  = 1'b0;
      out_enq__ENA = 1'b0;
      out_enq_v    = '0;
      xfer         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start__ENA && !abort__ENA) begin
               if (start_count <= DEPTH_C) begin
                  cnt_d    = start_count;
                  remain_d = {start_count, 1'b0};
                  csum_d   = '0;
                  odd_d    = 1'b0;
                  state_d  = HDR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         HDR: begin
            out_enq_v    = owidth'({tag, hdr_count});
            out_enq__ENA = out_enq__RDY && !abort__ENA;
            if (out_enq__ENA)
               state_d = (remain_q != '0) ? DATA : TRAIL;
         end
         DATA: begin
            out_enq_v    = in_first;
            xfer         = in_first__RDY && in_deq__RDY && out_enq__RDY && !abort__ENA;
            in_deq__ENA  = xfer;
            out_enq__ENA = xfer;
            if (xfer) begin
               csum_d = csum_q ^ in_first;
               odd_d  = !odd_q;
               // misaligned entry is flagged but the word still flows
               if (in_last != odd_q)
                  err_d = 1'b1;
               if (remain_q != '0)
                  remain_d = remain_q - RW'(1);
               if (remain_q <= RW'(1))
                  state_d = TRAIL;
            end
         end
         TRAIL: begin
            out_enq_v    = csum_q;
            out_enq__ENA = out_enq__RDY && !abort__ENA;
            if (out_enq__ENA)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort__ENA && state_q != IDLE)
         state_d = IDLE;
   end

endmodule

// File: tb/tb_trace_drain.sv
// Directed bench for trace_drain: framing, stalls, alignment errors, abort,
// bounds and reset behaviour.

module tb_trace_drain;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        start_ena;
   logic [10:0] start_count;
   logic        start_rdy;
   logic        abort_ena;
   logic        abort_rdy;
   logic [31:0] in_first;
   logic        in_first_rdy;
   logic        in_last;
   logic        deq_ena;
   logic        deq_rdy;
   logic        out_ena;
   logic [31:0] out_v;
   logic        out_rdy;
   logic        busy;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] src_w [0:15];
   bit          src_l [0:15];
   int          src_n, src_idx;
   logic [31:0] got [$];

   logic        s_busy, s_err, s_ena, s_deq, s_srdy;
   logic [31:0] s_v;

   always #5 CLK = ~CLK;

   trace_drain dut (
      .CLK(CLK), .nRST(nRST),
      .start__ENA(start_ena), .start_count(start_count), .start__RDY(start_rdy),
      .abort__ENA(abort_ena), .abort__RDY(abort_rdy),
      .in_first(in_first), .in_first__RDY(in_first_rdy), .in_last(in_last),
      .in_deq__ENA(deq_ena), .in_deq__RDY(deq_rdy),
      .out_enq__ENA(out_ena), .out_enq_v(out_v), .out_enq__RDY(out_rdy),
      .busy(busy), .error(error)
   );

   // One clock: drive at negedge, sample 1ns later, then wait for the next negedge.
   task automatic cycle(input bit ordy, input bit frdy);
      bit have;
      have         = (src_idx < src_n);
      in_first     = have ? src_w[src_idx] : 32'h0;
      in_last      = have ? src_l[src_idx] : 1'b0;
      in_first_rdy = frdy && have;
      deq_rdy      = 1'b1;
      out_rdy      = ordy;
      #1;
      s_busy = busy; s_err = error; s_ena = out_ena; s_deq = deq_ena;
      s_srdy = start_rdy; s_v = out_v;
      n_checks++;
      if (out_ena && !out_rdy) begin
         n_fail++; $display("FAIL ena_without_rdy: out ena=%b rdy=%b", out_ena, out_rdy);
      end
      n_checks++;
      if (deq_ena && !(deq_rdy && in_first_rdy)) begin
         n_fail++; $display("FAIL deq_without_rdy: deq=%b first_rdy=%b", deq_ena, in_first_rdy);
      end
      if (out_ena) got.push_back(out_v);
      if (deq_ena) src_idx++;
      @(negedge CLK);
   endtask

   task automatic do_start(input int cnt);
      got.delete();
      start_ena   = 1'b1;
      start_count = 11'(cnt);
      cycle(1'b1, 1'b1);
      start_ena   = 1'b0;
   endtask

   // mode 0: both sides always ready; mode 1: sink toggles, source stalls every third cycle
   task automatic run_until_idle(input int mode, output int ncyc);
      bit done;
      done = 0;
      ncyc = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         if (mode == 1) cycle(k % 2 == 0, k % 3 != 2);
         else           cycle(1'b1, 1'b1);
         if (s_busy) ncyc++;
         else        done = 1;
      end
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL idle_timeout: busy still %b after 100 cycles", s_busy);
      end
   endtask

   task automatic check_got(input string name, input logic [31:0] exp [$]);
      n_checks++;
      if (got.size() != exp.size()) begin
         n_fail++; $display("FAIL %s_len: got %0d words, expected %0d", name, got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin
            n_fail++; $display("FAIL %s_word%0d: got %h, expected %h", name, i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      nRST = 1'b1;
      n_checks++;
      if ({s_srdy, s_busy, s_err, s_ena, s_deq} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_flags: srdy,busy,err,ena,deq=%b expected 10000",
                            {s_srdy, s_busy, s_err, s_ena, s_deq});
      end
      n_checks++;
      if (s_v !== 32'h0) begin
         n_fail++; $display("FAIL reset_outv: got %h expected 0", s_v);
      end
      n_checks++;
      if (abort_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_abort_rdy: got %b expected 1", abort_rdy);
      end
   endtask

   task automatic test_basic;
      int nc;
      src_w[0] = 1; src_w[1] = 2; src_w[2] = 3; src_w[3] = 4;
      src_l[0] = 0; src_l[1] = 1; src_l[2] = 0; src_l[3] = 1;
      src_n = 4; src_idx = 0;
      do_start(2);
      run_until_idle(0, nc);
      check_got("basic", '{32'hA5000002, 1, 2, 3, 4, 32'h4});
      n_checks++;
      if (nc != 6) begin
         n_fail++; $display("FAIL basic_cycles: got %0d expected 6", nc);
      end
      n_checks++;
      if (s_err !== 1'b0) begin
         n_fail++; $display("FAIL basic_error: got %b expected 0", s_err);
      end
   endtask

   task automatic test_zero;
      int nc;
      src_n = 0; src_idx = 0;
      do_start(0);
      run_until_idle(0, nc);
      check_got("zero", '{32'hA5000000, 32'h0});
      n_checks++;
      if (nc != 2) begin
         n_fail++; $display("FAIL zero_cycles: got %0d expected 2", nc);
      end
   endtask

   task automatic test_backpressure;
      int nc;
      for (int i = 0; i < 8; i++) begin
         src_w[i] = 32'(1) << i;
         src_l[i] = i[0];
      end
      src_n = 8; src_idx = 0;
      do_start(4);
      run_until_idle(1, nc);
      check_got("bp", '{32'hA5000004, 1, 2, 4, 8, 16, 32, 64, 128, 32'hFF});
      n_checks++;
      if (s_err !== 1'b0) begin
         n_fail++; $display("FAIL bp_error: got %b expected 0", s_err);
      end
   endtask

   task automatic test_misalign;
      int nc;
      src_w[0] = 32'hAAAA0000; src_l[0] = 1;
      src_w[1] = 32'h0000BBBB; src_l[1] = 0;
      src_n = 2; src_idx = 0;
      do_start(1);
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_v !== 32'hA5000001 || s_ena !== 1'b1) begin
         n_fail++; $display("FAIL mis_header: got %h ena=%b expected a5000001 ena=1", s_v, s_ena);
      end
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_err !== 1'b0 || s_deq !== 1'b1) begin
         n_fail++; $display("FAIL mis_first: err=%b deq=%b expected err=0 deq=1", s_err, s_deq);
      end
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_err !== 1'b1) begin
         n_fail++; $display("FAIL mis_err_rise: got %b expected 1", s_err);
      end
      run_until_idle(0, nc);
      check_got("mis", '{32'hA5000001, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAABBBB});
      n_checks++;
      if (s_err !== 1'b1) begin
         n_fail++; $display("FAIL mis_err_sticky: got %b expected 1", s_err);
      end
   endtask

   task automatic test_abort;
      int nc;
      for (int i = 0; i < 16; i++) begin
         src_w[i] = 32'h100 + 32'(i);
         src_l[i] = i[0];
      end
      src_n = 16; src_idx = 0;
      do_start(8);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      abort_ena = 1'b1;
      cycle(1'b1, 1'b1);
      abort_ena = 1'b0;
      n_checks++;
      if (s_deq !== 1'b0 || s_ena !== 1'b0) begin
         n_fail++; $display("FAIL abort_gate: deq=%b ena=%b expected 0 0", s_deq, s_ena);
      end
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_busy !== 1'b0 || s_ena !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle: busy=%b ena=%b expected 0 0", s_busy, s_ena);
      end
      n_checks++;
      if (src_idx != 2) begin
         n_fail++; $display("FAIL abort_deq_count: got %0d expected 2", src_idx);
      end
      check_got("abort", '{32'hA5000008, 32'h100, 32'h101});
      do_start(1);
      run_until_idle(0, nc);
      check_got("after_abort", '{32'hA5000001, 32'h102, 32'h103, 32'h1});
   endtask

   task automatic test_bounds;
      nRST = 1'b0;
      cycle(1'b1, 1'b1);
      nRST = 1'b1;
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_err !== 1'b0) begin
         n_fail++; $display("FAIL bounds_pre_err: got %b expected 0", s_err);
      end
      src_n = 0; src_idx = 0;
      do_start(1025);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      n_checks++;
      if (s_err !== 1'b1 || s_busy !== 1'b0 || s_srdy !== 1'b1) begin
         n_fail++; $display("FAIL bounds_reject: err=%b busy=%b srdy=%b expected 1 0 1",
                            s_err, s_busy, s_srdy);
      end
      n_checks++;
      if (got.size() != 0) begin
         n_fail++; $display("FAIL bounds_output: got %0d words expected 0", got.size());
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 8; i++) begin
         src_w[i] = 32'h200 + 32'(i);
         src_l[i] = i[0];
      end
      src_n = 8; src_idx = 0;
      do_start(4);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      nRST = 1'b0;
      cycle(1'b1, 1'b1);
      nRST = 1'b1;
      n_checks++;
      if (s_busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pre: busy=%b expected 1", s_busy);
      end
      cycle(1'b1, 1'b1);
      n_checks++;
      if ({s_srdy, s_busy, s_err, s_ena, s_deq} !== 5'b10000 || s_v !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid_post: srdy,busy,err,ena,deq=%b v=%h expected 10000 0",
                            {s_srdy, s_busy, s_err, s_ena, s_deq}, s_v);
      end
   endtask

   initial begin
      nRST = 1'b0; start_ena = 1'b0; start_count = '0; abort_ena = 1'b0;
      in_first = '0; in_first_rdy = 1'b0; in_last = 1'b0; deq_rdy = 1'b1; out_rdy = 1'b1;
      src_n = 0; src_idx = 0;
      @(negedge CLK);
      test_reset;
      test_basic;
      test_zero;
      test_backpressure;
      test_misalign;
      test_abort;
      test_bounds;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
